// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/execute sequencer.
//   state_e        : sequencer states, 3-bit encoding
//   JNone..JMp     : C-instruction jump codes (instr[2:0])
//   InstrCBit      : bit that marks a C-instruction
//   JumpLsb        : LSB of the 3-bit jump field
package fetch_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StUpdate = 3'd4,
      StHalt   = 3'd5
   } state_e;

   localparam logic [2:0] JNone = 3'b000;
   localparam logic [2:0] JGt   = 3'b001;
   localparam logic [2:0] JEq   = 3'b010;
   localparam logic [2:0] JGe   = 3'b011;
   localparam logic [2:0] JLt   = 3'b100;
   localparam logic [2:0] JNe   = 3'b101;
   localparam logic [2:0] JLe   = 3'b110;
   localparam logic [2:0] JMp   = 3'b111;

   localparam int unsigned InstrCBit = 15;
   localparam int unsigned JumpLsb   = 0;

endpackage

// File: rtl/jump_cond.sv
// Jump condition evaluator (combinational).
//   j_i    : 3-bit jump code
//   zr_i   : ALU result zero
//   ng_i   : ALU result negative
//   take_o : 1 when the jump condition holds
module jump_cond
   import fetch_pkg::*;
(
   input  logic [2:0] j_i,
   input  logic       zr_i,
   input  logic       ng_i,
   output logic       take_o
);

   always_comb begin
      take_o = 1'b0;
      unique case (j_i)
         JNone: take_o = 1'b0;
         JGt:   take_o = !ng_i && !zr_i;
         JEq:   take_o = zr_i;
         JGe:   take_o = !ng_i;
         JLt:   take_o = ng_i;
         JNe:   take_o = !zr_i;
         JLe:   take_o = ng_i || zr_i;
         JMp:   take_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute controller: fetches one instruction via req/ack, hands it to the
// datapath, waits for exec_done and then pulses the PC to increment or jump.
//   clk_i, rst_ni           : clock, async active-low reset
//   run_i, halt_req_i       : run permission level, sticky halt request
//   pc_value_i              : current PC
//   pc_inc_o/pc_load_o      : PC update pulses; pc_data_o is the jump target
//   imem_req_o/imem_addr_o  : instruction fetch request/address
//   imem_ack_i/imem_rdata_i : fetch response
//   instr_o/instr_valid_o   : latched instruction, pulse when newly latched
//   exec_done_i             : datapath finished
//   a_reg_i, alu_zr_i/ng_i  : jump target and ALU flags
//   halted_o, fault_o       : stopped, fetch timeout
//   retired_o               : completed instruction count
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int unsigned WIDTH          = 16,
   parameter int unsigned FETCH_TIMEOUT  = 15,
   parameter bit          SELF_LOOP_HALT = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             run_i,
   input  logic             halt_req_i,
   input  logic [WIDTH-1:0] pc_value_i,
   output logic             pc_inc_o,
   output logic             pc_load_o,
   output logic [WIDTH-1:0] pc_data_o,
   output logic             imem_req_o,
   output logic [WIDTH-1:0] imem_addr_o,
   input  logic             imem_ack_i,
   input  logic [WIDTH-1:0] imem_rdata_i,
   output logic [WIDTH-1:0] instr_o,
   output logic             instr_valid_o,
   input  logic             exec_done_i,
   input  logic [WIDTH-1:0] a_reg_i,
   input  logic             alu_zr_i,
   input  logic             alu_ng_i,
   output logic             halted_o,
   output logic             fault_o,
   output logic [WIDTH-1:0] retired_o
);

   localparam logic [7:0] TimeoutLast = 8'(FETCH_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] instr_q, instr_d;
   logic [WIDTH-1:0] retired_q, retired_d;
   logic [7:0]       tmo_q, tmo_d;
   logic             halt_q, halt_d;
   logic             fault_q, fault_d;
   logic             zr_q, zr_d;
   logic             ng_q, ng_d;

   logic       take;
   logic       jump;
   logic       self_loop;
   logic       halt_pend;
   logic [2:0] jcode;

   assign jcode = instr_q[JumpLsb +: 3];

   jump_cond u_jump_cond (
      .j_i    (jcode),
      .zr_i   (zr_q),
      .ng_i   (ng_q),
      .take_o (take)
   );

   assign jump      = instr_q[InstrCBit] && take;
   // Unconditional jump to itself: the program has ended.
   assign self_loop = SELF_LOOP_HALT && instr_q[InstrCBit] && (jcode == JMp) &&
                      (a_reg_i == pc_value_i);
   // A request arriving in the boundary cycle itself must not be lost.
   assign halt_pend = halt_q || halt_req_i;

   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      retired_d = retired_q;
      tmo_d     = tmo_q;
      halt_d    = halt_pend;
      fault_d   = fault_q;
      zr_d      = zr_q;
      ng_d      = ng_q;
      unique case (state_q)
         StIdle: begin
            if (halt_pend) begin
               state_d = StHalt;
            end else if (run_i) begin
               state_d = StFetch;
            end
         end
         StFetch: begin
            // Ack has priority over a timeout landing in the same cycle.
            if (imem_ack_i) begin
               instr_d = imem_rdata_i;
               tmo_d   = 8'd0;
               state_d = StDecode;
            end else if (tmo_q == TimeoutLast) begin
               tmo_d   = 8'd0;
               fault_d = 1'b1;
               state_d = StHalt;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         StDecode: state_d = StExec;
         StExec: begin
            if (exec_done_i) begin
               zr_d    = alu_zr_i;
               ng_d    = alu_ng_i;
               state_d = StUpdate;
            end
         end
         StUpdate: begin
            retired_d = retired_q + WIDTH'(1);
            if (halt_pend || self_loop) begin
               state_d = StHalt;
            end else if (run_i) begin
               state_d = StFetch;
            end else begin
               state_d = StIdle;
            end
         end
         StHalt: state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         instr_q   <= '0;
         retired_q <= '0;
         tmo_q     <= 8'd0;
         halt_q    <= 1'b0;
         fault_q   <= 1'b0;
         zr_q      <= 1'b0;
         ng_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
         tmo_q     <= tmo_d;
         halt_q    <= halt_d;
         fault_q   <= fault_d;
         zr_q      <= zr_d;
         ng_q      <= ng_d;
      end
   end

   // Outputs decode the state register only; no path from ack/done.
   assign imem_req_o    = (state_q == StFetch);
   assign imem_addr_o   = imem_req_o ? pc_value_i : '0;
   assign instr_valid_o = (state_q == StDecode);
   assign pc_load_o     = (state_q == StUpdate) && jump;
   assign pc_inc_o      = (state_q == StUpdate) && !jump;
   assign pc_data_o     = pc_load_o ? a_reg_i : '0;
   assign halted_o      = (state_q == StHalt);
   assign fault_o       = fault_q;
   assign instr_o       = instr_q;
   assign retired_o     = retired_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Fetch/execute controller that sequences the 16-bit program counter, the instruction memory port and the datapath, one instruction at a time.
- Each instruction is fetched through a req/ack handshake, handed to the datapath, and completed when the datapath signals done.
- On completion the block commands the PC to either increment or load the jump target, based on the C-instruction jump bits and the ALU flags.
- It also handles run/halt control, fetch-timeout faults and retired-instruction counting.

Parameters:
- WIDTH, 16, data/address width.
- FETCH_TIMEOUT, 15, maximum cycles to wait for imem_ack before faulting (1..255).
- SELF_LOOP_HALT, 1, when 1 an unconditional jump to its own address halts the machine.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 permits fetching.
- halt_req  in  1  pulse; request halt at the next instruction boundary.
- pc_value  in  WIDTH  current PC output.
- pc_inc  out  1  one-cycle pulse; PC += 1.
- pc_load  out  1  one-cycle pulse; PC <= pc_data.
- pc_data  out  WIDTH  jump target; valid while pc_load=1, else 0.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  WIDTH  fetch address.
- imem_ack  in  1  fetch data valid.
- imem_rdata  in  WIDTH  fetched instruction.
- instr  out  WIDTH  latched current instruction.
- instr_valid  out  1  one-cycle pulse when instr is newly latched.
- exec_done  in  1  datapath finished the current instruction.
- a_reg  in  WIDTH  A register, used as the jump target.
- alu_zr  in  1  ALU result zero.
- alu_ng  in  1  ALU result negative.
- halted  out  1  machine stopped.
- fault  out  1  fetch timeout occurred.
- retired  out  WIDTH  count of completed instructions.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0: instr, retired, timeout counter, sticky halt flag.
  - Takes effect mid-fetch or mid-execute; imem_req drops without waiting for a clock.
- States: IDLE, FETCH, DECODE, EXEC, UPDATE, HALT.
- IDLE:
  - run=1 goes to FETCH next cycle; otherwise stay.
  - halt_req in IDLE goes to HALT.
- FETCH:
  - imem_req=1, imem_addr=pc_value, both held stable until ack.
  - The timeout counter increments each cycle without ack.
  - imem_ack=1: instr<=imem_rdata, counter cleared, go to DECODE.
  - Counter reaches FETCH_TIMEOUT with no ack: fault<=1, halted<=1, go to HALT.
  - An ack arriving in the same cycle as the timeout wins (no fault).
- DECODE:
  - One cycle; instr_valid=1; always go to EXEC.
- EXEC:
  - Wait for exec_done=1; on it, sample alu_zr/alu_ng and go to UPDATE.
  - There is no timeout in EXEC.
- UPDATE: one cycle; exactly one of pc_inc and pc_load is 1.
  - Jump is taken only if instr[15]=1, using jump bits j=instr[2:0]:
    - 000 never
    - 001 !ng&!zr
    - 010 zr
    - 011 !ng
    - 100 ng
    - 101 !zr
    - 110 ng|zr
    - 111 always
  - Taken: pc_load=1, pc_data=a_reg. Not taken: pc_inc=1.
  - retired increments, wrapping 0xFFFF to 0.
  - Next state:
    - HALT if the sticky halt flag is set, or if SELF_LOOP_HALT=1 and j=111 and a_reg==pc_value (the PC pulse is still issued); halted<=1.
    - Else FETCH if run=1.
    - Else IDLE.
- halt_req:
  - Latched sticky in any state and cleared only by reset.
  - Never aborts an instruction in flight; it takes effect at UPDATE.
- run=0 mid-instruction: the instruction completes normally, then the block goes to IDLE.
- imem_ack outside FETCH and exec_done outside EXEC are ignored.
- HALT: absorbing; only reset exits. halted=1 and fault holds its value.
- Minimum instruction latency is 4 cycles (FETCH with same-cycle ack, DECODE, EXEC with same-cycle done, UPDATE). Back-to-back fetches are therefore 4 cycles apart.
- Outputs pc_inc, pc_load, instr_valid and imem_req are registered decodes of state: no combinational path from imem_ack or exec_done to any output.

Decomposition:
- Shared package fetch_pkg:
  - State encoding constants (3-bit): IDLE=0, FETCH=1, DECODE=2, EXEC=3, UPDATE=4, HALT=5.
  - Jump-code constants JNONE..JMP.
  - Instruction field positions: INSTR_C_BIT=15, JUMP_LSB=0.
- One sub-module, jump_cond: combinational; inputs j[2:0], zr, ng; output take. Reused later by the branch predictor/trace unit.

Test Plan:
- Reset then run=1; ack and exec_done in the first cycle of their states; A-instructions 0x0005, 0x0006 -> pc_inc pulses every 4 cycles, retired=2, no pc_load.
- C-instr 0xE302 (JEQ) with alu_zr=1, a_reg=0x0040 -> pc_load=1, pc_data=0x0040; repeat with zr=0 -> pc_inc=1.
- Sweep j=000..111 against (zr,ng) in {00,01,10} -> take matches the condition list for all 24 cases.
- Withhold imem_ack for FETCH_TIMEOUT cycles -> fault=1, halted=1, imem_req=0, no PC pulse. A variant with ack on exactly the timeout cycle -> no fault.
- halt_req pulsed during EXEC -> instruction completes, one PC pulse, then halted=1. Further ack/done/run activity is ignored.
- pc_value=0x0010, a_reg=0x0010, instr=0xEA87 (JMP) -> pc_load then HALT. Assert reset mid-FETCH -> imem_req falls asynchronously and all outputs are 0.
